// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-index width, datapath width and the
// hazard sequencer state encodings used by ID/EX control and debug ports.
package idex_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

endpackage

// File: rtl/idex_hazard_ctrl_hazard_detect.sv
// Load-use hazard equation: ID source register matches a pending load's rd.
// Purely combinational, zero latency; x0 never produces a hazard.
module idex_hazard_ctrl_hazard_detect
  import idex_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 reg_write,
  input  logic                 mem_read,
  output logic                 hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = uses_rs1 && (rs1 == rd);
  assign rs2_match = uses_rs2 && (rs2 == rd);
  assign hazard    = mem_read && reg_write && (rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/idex_hazard_ctrl.sv
// IF/ID and ID/EX sequencer: load-use bubbles, branch flushes, memory-wait freeze.
// Controls act in the same cycle; MEMbusy overrides everything and freezes the pipe.
module idex_hazard_ctrl
  import idex_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [REG_IDX_W-1:0] IDrs1,
  input  logic [REG_IDX_W-1:0] IDrs2,
  input  logic                 IDusesRs1,
  input  logic                 IDusesRs2,
  input  logic [REG_IDX_W-1:0] IDEXrd,
  input  logic                 IDEXregWrite,
  input  logic                 IDEXmemRead,
  input  logic                 EXbranchTaken,
  input  logic                 MEMbusy,
  output logic                 PCwrite,
  output logic                 IFIDwrite,
  output logic                 IFIDflush,
  output logic                 IDEXhold,
  output logic                 IDEXbubble,
  output logic [1:0]           State,
  output logic [CNT_W-1:0]     StallCount
);

  localparam logic [2:0] FLUSH_M1 = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       hazard;
  logic       pc_we, ifid_we, ifid_fl, idex_hd, idex_bb;

  idex_hazard_ctrl_hazard_detect u_hazard (
    .rs1       (IDrs1),
    .rs2       (IDrs2),
    .uses_rs1  (IDusesRs1),
    .uses_rs2  (IDusesRs2),
    .rd        (IDEXrd),
    .reg_write (IDEXregWrite),
    .mem_read  (IDEXmemRead),
    .hazard    (hazard)
  );

  // LOADUSE and a released MEMWAIT evaluate exactly like RUN.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    ifid_fl = 1'b0;
    idex_hd = 1'b0;
    idex_bb = 1'b0;
    if (MEMbusy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_hd = 1'b1;
      if (state_q != ST_FLUSH) state_d = ST_MEMWAIT;
    end else if (state_q == ST_FLUSH) begin
      ifid_fl = 1'b1;
      idex_bb = 1'b1;
      if (fcnt_q <= 3'd1) begin
        fcnt_d  = 3'd0;
        state_d = ST_RUN;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end else if (EXbranchTaken) begin
      ifid_fl = 1'b1;
      idex_bb = 1'b1;
      fcnt_d  = FLUSH_M1;
      state_d = (FLUSH_M1 != 3'd0) ? ST_FLUSH : ST_RUN;
    end else if (hazard) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_bb = 1'b1;
      state_d = ST_LOADUSE;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_RUN;
      fcnt_q     <= 3'd0;
      StallCount <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!pc_we && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
    end
  end

  // While in reset the pipe is held with a bubble entering ID/EX.
  assign PCwrite    = RST_N && pc_we;
  assign IFIDwrite  = RST_N && ifid_we;
  assign IFIDflush  = RST_N && ifid_fl;
  assign IDEXhold   = RST_N && idex_hd;
  assign IDEXbubble = !RST_N || (idex_bb && !idex_hd);
  assign State      = state_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Randomized and directed bench for idex_hazard_ctrl against a cycle-level reference model.
module tb_idex_hazard_ctrl;

  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic [4:0]    IDrs1, IDrs2, IDEXrd;
  logic          IDusesRs1, IDusesRs2, IDEXregWrite, IDEXmemRead, EXbranchTaken, MEMbusy;
  logic          PCwrite, IFIDwrite, IFIDflush, IDEXhold, IDEXbubble;
  logic [1:0]    State;
  logic [CW-1:0] StallCount;
  logic [4:0]    ctl;

  int n_cmp = 0;
  int n_err = 0;
  int m_state, m_flush_left, m_stall;

  idex_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .IDrs1         (IDrs1),
    .IDrs2         (IDrs2),
    .IDusesRs1     (IDusesRs1),
    .IDusesRs2     (IDusesRs2),
    .IDEXrd        (IDEXrd),
    .IDEXregWrite  (IDEXregWrite),
    .IDEXmemRead   (IDEXmemRead),
    .EXbranchTaken (EXbranchTaken),
    .MEMbusy       (MEMbusy),
    .PCwrite       (PCwrite),
    .IFIDwrite     (IFIDwrite),
    .IFIDflush     (IFIDflush),
    .IDEXhold      (IDEXhold),
    .IDEXbubble    (IDEXbubble),
    .State         (State),
    .StallCount    (StallCount)
  );

  always #5 CLK = ~CLK;

  assign ctl = {PCwrite, IFIDwrite, IFIDflush, IDEXhold, IDEXbubble};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    IDrs1 = 0; IDrs2 = 0; IDEXrd = 0;
    IDusesRs1 = 0; IDusesRs2 = 0; IDEXregWrite = 0; IDEXmemRead = 0;
    EXbranchTaken = 0; MEMbusy = 0;
  endtask

  // Holds reset mid-cycle, checks the reset outputs, releases on a falling edge.
  task automatic do_reset();
    zero_inputs();
    RST_N = 1'b0;
    #3;
    check("rst_state", 32'(State), 0);
    check("rst_cnt", 32'(StallCount), 0);
    check("rst_ctl", 32'(ctl), 32'b00001);
    @(negedge CLK);
    RST_N = 1'b1;
    m_state = 0; m_flush_left = 0; m_stall = 0;
  endtask

  // One pipeline cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit mb, input bit br, input bit mr, input bit rw, input logic [4:0] rd,
                      input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
    bit hz;
    logic [4:0] e_ctl;
    @(negedge CLK);
    MEMbusy = mb; EXbranchTaken = br; IDEXmemRead = mr; IDEXregWrite = rw; IDEXrd = rd;
    IDrs1 = rs1; IDusesRs1 = u1; IDrs2 = rs2; IDusesRs2 = u2;
    #1;
    hz = mr && rw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (mb)                          e_ctl = 5'b00010;
    else if (m_flush_left > 0 || br) e_ctl = 5'b11101;
    else if (hz)                     e_ctl = 5'b00001;
    else                             e_ctl = 5'b11000;
    check("state", 32'(State), m_state);
    check("stall_cnt", 32'(StallCount), m_stall);
    check("ctl", 32'(ctl), 32'(e_ctl));
    if (!e_ctl[4] && m_stall < SAT) m_stall++;
    if (mb) begin
      m_state = (m_flush_left > 0) ? 2 : 3;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_state = (m_flush_left > 0) ? 2 : 0;
    end else if (br) begin
      m_flush_left = FC - 1;
      m_state = (m_flush_left > 0) ? 2 : 0;
    end else begin
      m_state = hz ? 1 : 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    zero_inputs();
    #1;
    do_reset();

    // lw x5 followed by add x6,x5,x7: one bubble then normal flow
    step(0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd7, 1);
    idle();
    // load to x0 consumed from x0: no stall
    step(0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    idle();
    // back-to-back dependent loads each take one bubble
    step(0, 0, 1, 1, 5'd3, 5'd1, 1, 5'd3, 1);
    step(0, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0);
    idle();
    // taken branch: two flush cycles
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // memory wait for three cycles in the middle of a flush
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // freeze, branch and hazard together; branch wins after release
    step(1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    step(0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    idle();
    idle();

    // asynchronous reset while in LOADUSE
    step(0, 0, 1, 1, 5'd2, 5'd2, 1, 5'd0, 0);
    @(posedge CLK);
    #2;
    check("pre_rst_state", 32'(State), m_state);
    check("pre_rst_cnt", 32'(StallCount), m_stall);
    do_reset();

    // randomized blocks; small register range makes hazards common
    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 40; c++) begin
        step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      do_reset();
    end

    // drive the counter into saturation
    for (int i = 0; i < SAT + 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
